// File: rtl/seq_monitor.sv
// Sequence monitor for the six-step counter bus: acquires lock, flywheels through misses,
// counts sequence errors and flags a stuck bus.
module seq_monitor #(
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned UNLOCK_N = 2,
  parameter int unsigned STUCK_N  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       VALID,
  input  logic [3:0] CODE,
  output logic       LOCKED,
  output logic       ERR,
  output logic [7:0] ERR_CNT,
  output logic       STUCK,
  output logic [2:0] POS
);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  // Indices 6 and 7 are never held in pos, so they share the last entry.
  function automatic logic [3:0] tbl_code(input logic [2:0] idx);
    case (idx)
      3'd0:    tbl_code = 4'h1;
      3'd1:    tbl_code = 4'h2;
      3'd2:    tbl_code = 4'h7;
      3'd3:    tbl_code = 4'h8;
      3'd4:    tbl_code = 4'hC;
      default: tbl_code = 4'h5;
    endcase
  endfunction

  function automatic logic [2:0] pos_inc(input logic [2:0] p);
    pos_inc = (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  state_e     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic [3:0] match_q, match_d;
  logic [3:0] miss_q, miss_d;
  logic [3:0] rep_q, rep_d;
  logic [3:0] prev_q, prev_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       stuck_q, stuck_d;

  logic       in_tbl;
  logic [2:0] tbl_idx;
  logic       exp_hit;
  logic [3:0] match_inc, miss_inc;

  always_comb begin
    in_tbl  = 1'b0;
    tbl_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (CODE == tbl_code(3'(i))) begin
        in_tbl  = 1'b1;
        tbl_idx = 3'(i);
      end
    end
    exp_hit   = (CODE == tbl_code(pos_q));
    match_inc = match_q + 4'd1;
    miss_inc  = miss_q + 4'd1;
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    match_d   = match_q;
    miss_d    = miss_q;
    rep_d     = rep_q;
    prev_d    = prev_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    stuck_d   = stuck_q;

    if (VALID) begin
      unique case (state_q)
        StSearch: begin
          if (in_tbl) begin
            pos_d   = pos_inc(tbl_idx);
            match_d = 4'd1;
            state_d = StVerify;
          end
        end
        StVerify: begin
          if (exp_hit) begin
            pos_d   = pos_inc(pos_q);
            match_d = match_inc;
            if (match_inc == 4'(LOCK_N)) begin
              state_d = StLocked;
              miss_d  = 4'd0;
            end
          end else if (in_tbl) begin
            // Mismatch may still be a valid starting point: restart verification from it.
            pos_d   = pos_inc(tbl_idx);
            match_d = 4'd1;
          end else begin
            state_d = StSearch;
          end
        end
        StLocked: begin
          pos_d = pos_inc(pos_q);
          if (exp_hit) begin
            miss_d = 4'd0;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            miss_d    = miss_inc;
            if (miss_inc == 4'(UNLOCK_N)) state_d = StSearch;
          end
        end
        default: state_d = StSearch;
      endcase

      if (CODE == prev_q) begin
        rep_d = (rep_q == 4'hF) ? rep_q : rep_q + 4'd1;
      end else begin
        rep_d = 4'd0;
      end
      prev_d  = CODE;
      stuck_d = (rep_d >= 4'(STUCK_N));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StSearch;
      pos_q     <= 3'd0;
      match_q   <= 4'd0;
      miss_q    <= 4'd0;
      rep_q     <= 4'd0;
      prev_q    <= 4'hF;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      rep_q     <= rep_d;
      prev_q    <= prev_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      stuck_q   <= stuck_d;
    end
  end

  assign LOCKED  = (state_q == StLocked);
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
  assign STUCK   = stuck_q;
  assign POS     = pos_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Scoreboard bench for seq_monitor: a behavioural model queues expected status per sample,
// which is popped and compared one edge later.
module tb_seq_monitor;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;
  localparam int STUCK_N  = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       VALID;
  logic [3:0] CODE;
  logic       LOCKED;
  logic       ERR;
  logic [7:0] ERR_CNT;
  logic       STUCK;
  logic [2:0] POS;

  seq_monitor #(
    .LOCK_N  (LOCK_N),
    .UNLOCK_N(UNLOCK_N),
    .STUCK_N (STUCK_N)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .VALID  (VALID),
    .CODE   (CODE),
    .LOCKED (LOCKED),
    .ERR    (ERR),
    .ERR_CNT(ERR_CNT),
    .STUCK  (STUCK),
    .POS    (POS)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic       stuck;
    logic [2:0] pos;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  int tbl[6] = '{4'h1, 4'h2, 4'h7, 4'h8, 4'hC, 4'h5};

  // Model state: 0 = search, 1 = verify, 2 = locked
  int m_state, m_pos, m_match, m_miss, m_rep, m_prev, m_cnt;
  bit m_err, m_stuck;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_match = 0; m_miss = 0;
    m_rep = 0; m_prev = 15; m_cnt = 0; m_err = 0; m_stuck = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input int c);
    int k;
    exp_t e;
    m_err = 0;
    if (v) begin
      k = -1;
      for (int i = 0; i < 6; i++) if (tbl[i] == c) k = i;
      case (m_state)
        0: if (k >= 0) begin m_pos = (k + 1) % 6; m_match = 1; m_state = 1; end
        1: begin
          if (c == tbl[m_pos]) begin
            m_pos = (m_pos + 1) % 6;
            m_match++;
            if (m_match == LOCK_N) begin m_state = 2; m_miss = 0; end
          end else if (k >= 0) begin
            m_pos = (k + 1) % 6; m_match = 1;
          end else begin
            m_state = 0;
          end
        end
        default: begin
          bit hit;
          hit = (c == tbl[m_pos]);
          m_pos = (m_pos + 1) % 6;
          if (hit) m_miss = 0;
          else begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
            m_miss++;
            if (m_miss == UNLOCK_N) m_state = 0;
          end
        end
      endcase
      if (c == m_prev) begin
        if (m_rep < 15) m_rep++;
      end else m_rep = 0;
      m_prev  = c;
      m_stuck = (m_rep >= STUCK_N);
    end
    e.locked = (m_state == 2);
    e.err    = m_err;
    e.cnt    = 8'(m_cnt);
    e.stuck  = m_stuck;
    e.pos    = 3'(m_pos);
    exp_q.push_back(e);
  endtask

  // Drive one sample, let the DUT register it, then compare against the scoreboard head.
  task automatic step(input bit v, input logic [3:0] c);
    exp_t e;
    VALID = v;
    CODE  = c;
    model_step(v, int'(c));
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("LOCKED", int'(LOCKED), int'(e.locked));
      check("ERR", int'(ERR), int'(e.err));
      check("ERR_CNT", int'(ERR_CNT), int'(e.cnt));
      check("STUCK", int'(STUCK), int'(e.stuck));
      check("POS", int'(POS), int'(e.pos));
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    VALID = 1'b0;
    CODE = 4'h0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_LOCKED"}, int'(LOCKED), 0);
    check({tag, "_ERR"}, int'(ERR), 0);
    check({tag, "_ERR_CNT"}, int'(ERR_CNT), 0);
    check({tag, "_STUCK"}, int'(STUCK), 0);
    check({tag, "_POS"}, int'(POS), 0);
  endtask

  task automatic acquire();
    step(1, 4'h1); step(1, 4'h2); step(1, 4'h7); step(1, 4'h8);
  endtask

  initial begin
    int seq_i;
    do_reset();
    check_zero("reset");

    // Acquire lock
    acquire();
    check("acq_locked", int'(LOCKED), 1);
    check("acq_pos", int'(POS), 4);
    check("acq_cnt", int'(ERR_CNT), 0);

    // Flywheel through one miss
    step(1, 4'hC);
    step(1, 4'h3);
    check("fly_err", int'(ERR), 1);
    check("fly_cnt", int'(ERR_CNT), 1);
    step(1, 4'h1);
    check("fly_locked", int'(LOCKED), 1);
    check("fly_pos", int'(POS), 1);

    // Loss of lock
    step(1, 4'h0);
    check("loss1_locked", int'(LOCKED), 1);
    step(1, 4'h0);
    check("loss2_err", int'(ERR), 1);
    check("loss2_locked", int'(LOCKED), 0);
    check("loss2_cnt", int'(ERR_CNT), 3);

    // Stuck bus
    do_reset();
    repeat (4) step(1, 4'h7);
    check("stuck_set", int'(STUCK), 1);
    step(1, 4'h8);
    check("stuck_clr", int'(STUCK), 0);

    // VALID gap mid-lock, then asynchronous reset between edges
    do_reset();
    acquire();
    step(1, 4'h0);
    repeat (10) step(0, 4'h3);
    check("gap_locked", int'(LOCKED), 1);
    check("gap_pos", int'(POS), 5);
    check("gap_cnt", int'(ERR_CNT), 1);
    RST = 1'b1;
    #2;
    check_zero("async_rst");
    #1;
    RST = 1'b0;
    model_reset();

    // Saturation via repeated lock/unlock
    for (int r = 0; r < 130; r++) begin
      acquire();
      step(1, 4'h0);
      step(1, 4'h0);
    end
    check("sat_cnt", int'(ERR_CNT), 255);
    acquire();
    step(1, 4'h3);
    check("sat_err", int'(ERR), 1);
    check("sat_hold", int'(ERR_CNT), 255);

    // Mismatching code in VERIFY restarts verification from its own index
    do_reset();
    step(1, 4'h1);
    step(1, 4'h8);
    check("reverify_pos", int'(POS), 4);
    check("reverify_locked", int'(LOCKED), 0);
    step(1, 4'hC); step(1, 4'h5); step(1, 4'h1);
    check("reverify_lock", int'(LOCKED), 1);

    // Mostly in-order random traffic with gaps, glitches and repeats
    do_reset();
    seq_i = 0;
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [3:0] c;
      sel = int'($urandom_range(0, 15));
      if (sel < 11) begin
        c = 4'(tbl[seq_i]);
        seq_i = (seq_i + 1) % 6;
      end else if (sel < 13) begin
        c = CODE;
      end else begin
        c = 4'($urandom_range(0, 15));
      end
      step(($urandom_range(0, 7) != 0), c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seq_monitor.md
# seq_monitor

Downstream checker for the 4-bit sequence-counter output bus. It samples the 4-bit code and acquires lock on the fixed six-step code cycle, then flywheels through misses. It counts sequence errors and flags a stuck bus. It sits directly behind the counter, on the same clock, and drives status LEDs and debug logic.

## Interface
- LOCK_N, 4: consecutive in-order samples, including the starting sample, required to enter LOCKED (2..15)
- UNLOCK_N, 2: consecutive misses in LOCKED that drop lock (1..15)
- STUCK_N, 3: consecutive repeats of the same code that raise STUCK (1..15)
- CLK  input  1  rising-edge clock; the only clock
- RST  input  1  asynchronous, active-high reset
- VALID  input  1  sample enable; CODE is evaluated only on edges where VALID=1
- CODE  input  4  code under test, from the counter bus
- LOCKED  output  1  high while the FSM is in LOCKED
- ERR  output  1  one-cycle pulse on each miss while LOCKED
- ERR_CNT  output  8  total misses while LOCKED; saturates at 255
- STUCK  output  1  high while the current code has repeated at least STUCK_N times
- POS  output  3  index (0..5) of the expected next code; meaningful in VERIFY and LOCKED

## Operation
- Expected cycle: index 0..5 = 0x1, 0x2, 0x7, 0x8, 0xC, 0x5, then back to index 0. A code not in the table is never a match.
- FSM states: SEARCH, VERIFY, LOCKED. Registers: match count (4b), miss count (4b), repeat count (4b), previous code (4b), POS.
- SEARCH:
  - If CODE is at table index k: POS<=k+1 mod 6, match count<=1, go to VERIFY.
  - Otherwise stay in SEARCH.
- VERIFY:
  - If CODE==table[POS]: POS advances, match count increments.
  - When the incremented match count equals LOCK_N: go to LOCKED and clear miss count.
  - On a mismatch: re-run the SEARCH evaluation on the same CODE in the same edge. If CODE is in the table, restart VERIFY from its index with match count=1; otherwise go to SEARCH.
  - No ERR is raised outside LOCKED.
- LOCKED:
  - POS advances on every valid sample, hit or miss (flywheel).
  - Hit: miss count<=0.
  - Miss: ERR pulses, ERR_CNT increments (saturating), miss count increments.
  - When the incremented miss count equals UNLOCK_N: go to SEARCH; LOCKED falls on that same edge.
- Stuck detect runs independently of the FSM:
  - On a valid sample with CODE==previous code: repeat count increments, saturating at 15.
  - On a valid sample with a different code: repeat count<=0.
  - Previous code<=CODE on every valid sample.
  - STUCK = (repeat count >= STUCK_N), registered.
  - A repeat is also a sequence miss, because the table has no repeated adjacent entries.
- VALID=0: all state holds, ERR=0.
- ERR_CNT clears only on RST.

## Timing
- All outputs are registered and update on the rising CLK edge that samples VALID=1. Latency is 1 cycle from sample to status.
- Reset values: FSM=SEARCH, LOCKED=0, ERR=0, ERR_CNT=0, STUCK=0, POS=0. Match, miss and repeat counts = 0. Previous code = 0xF (not in the table).
- Asserting RST mid-operation clears every register immediately, without waiting for a clock edge.
- After RST falls, the first rising edge with VALID=1 is evaluated as a SEARCH sample.
- Minimum time to lock: LOCK_N valid samples. LOCKED rises on the edge of the LOCK_N-th in-order sample.
- Miss in the same edge that reaches UNLOCK_N: ERR pulses, ERR_CNT increments, and the FSM enters SEARCH. The sample is not re-evaluated for acquisition.
- ERR_CNT at 255 plus a further miss: ERR still pulses; ERR_CNT stays 255.
- POS wraps from 5 to 0 with no gap.

## Test plan
- Acquire lock: reset, then feed 0x1,0x2,0x7,0x8 with VALID=1 each cycle. LOCKED=1 after the 4th edge, POS=4, ERR_CNT=0.
- Flywheel: while locked, feed 0xC, 0x3 (miss), 0x1. One ERR pulse on the 0x3 edge, ERR_CNT=1, LOCKED stays 1, POS=1 after the 0x1 edge.
- Loss of lock: while locked, feed two consecutive wrong codes 0x0, 0x0. ERR pulses twice, ERR_CNT+2, LOCKED=0 on the 2nd edge.
- Stuck bus: feed 0x7 four times. STUCK=1 after the 4th edge (3 repeats). Then feed 0x8: STUCK=0 on the next edge.
- VALID gaps and reset: hold VALID=0 for 10 cycles mid-lock; LOCKED, POS and ERR_CNT are unchanged. Pulse RST between clock edges; all outputs read 0 (POS=0) before the next edge.
- Saturation and re-acquisition: force 260 misses through repeated lock/unlock. ERR_CNT=255 and holds. A mismatching 0x8 in VERIFY restarts VERIFY with POS=4.
